// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU sequencer: opcode encoding, FSM state
//   enumeration, the decoded control-vector bundle and small opcode helpers.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_ASL = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_OPER  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_e;

    // Everything the sequencer drives toward the ALU / accumulator fabric.
    typedef struct packed {
        logic sb_add;
        logic db_add;
        logic ndb_add;
        logic z_add;
        logic adl_add;
        logic ands;
        logic eors;
        logic ors;
        logic srs;
        logic sums;
        logic n_acin;
        logic n_daa;
        logic n_dsa;
        logic ac_sb;
        logic ac_db;
        logic sb_ac;
        logic add_sb06;
        logic add_sb7;
        logic busy;
        logic done;
    } alu_ctrl_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_INC;
    endfunction

    // Ops whose ALU carry-out becomes the new carry flag.
    function automatic logic op_sets_c(input logic [3:0] op);
        case (op)
            OP_ADC, OP_SBC, OP_CMP, OP_ASL, OP_ROL, OP_LSR: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic op_sets_v(input logic [3:0] op);
        return (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
//   Purely combinational decode of FSM state + latched request into the full
//   ALU control vector.
//   Ports: state (FSM state), op (latched opcode), d_lat / c_lat (latched
//          decimal and carry flags), ctrl (decoded control bundle).
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  seq_state_e state,
    input  logic [3:0] op,
    input  logic       d_lat,
    input  logic       c_lat,
    output alu_ctrl_t  ctrl
);

    logic carry_in;

    always_comb begin
        case (op)
            OP_ADC, OP_SBC, OP_ROL: carry_in = c_lat;
            OP_CMP, OP_INC:         carry_in = 1'b1;
            default:                carry_in = 1'b0;
        endcase
    end

    always_comb begin
        ctrl        = '0;
        ctrl.n_acin = 1'b1;
        ctrl.n_daa  = 1'b1;
        ctrl.n_dsa  = 1'b1;
        case (state)
            ST_LOAD: begin
                ctrl.busy   = 1'b1;
                ctrl.ac_sb  = 1'b1;
                ctrl.sb_add = 1'b1;
                case (op)
                    OP_SBC, OP_CMP: ctrl.ndb_add = 1'b1;
                    // Shift-left ops feed A on both inputs to form A+A.
                    OP_ASL, OP_ROL: begin
                        ctrl.ac_db  = 1'b1;
                        ctrl.db_add = 1'b1;
                    end
                    OP_LSR, OP_INC: ctrl.z_add = 1'b1;
                    default:        ctrl.db_add = 1'b1;
                endcase
            end
            ST_OPER: begin
                ctrl.busy = 1'b1;
                case (op)
                    OP_AND:  ctrl.ands = 1'b1;
                    OP_ORA:  ctrl.ors  = 1'b1;
                    OP_EOR:  ctrl.eors = 1'b1;
                    OP_LSR:  ctrl.srs  = 1'b1;
                    default: ctrl.sums = 1'b1;
                endcase
                ctrl.n_acin = ~carry_in;
                ctrl.n_daa  = ~((op == OP_ADC) && d_lat);
                ctrl.n_dsa  = ~((op == OP_SBC) && d_lat);
            end
            ST_WRITE: begin
                ctrl.busy     = 1'b1;
                ctrl.done     = 1'b1;
                ctrl.add_sb06 = 1'b1;
                ctrl.add_sb7  = 1'b1;
                // Compare only sets flags; the accumulator keeps its value.
                ctrl.sb_ac    = (op != OP_CMP);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Runs one accumulator operation per request over LOAD/OPER/WRITE, driving
//   the ALU input/op selects and bus transfers, and capturing ACR/AVR into
//   the carry/overflow flags at the end of OPER.
//   Ports: PHI2 clock, RES async active-high reset; START/OP/D_FLAG/C_IN
//          request; ACR/AVR ALU results; *_ADD, ANDS..SUMS, n_* and transfer
//          controls toward the datapath; BUSY, DONE, ERR status; C_OUT/V_OUT
//          registered flags.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic       PHI2,
    input  logic       RES,
    input  logic       START,
    input  logic [3:0] OP,
    input  logic       D_FLAG,
    input  logic       C_IN,
    input  logic       ACR,
    input  logic       AVR,
    output logic       SB_ADD,
    output logic       DB_ADD,
    output logic       NDB_ADD,
    output logic       Z_ADD,
    output logic       ADL_ADD,
    output logic       ANDS,
    output logic       EORS,
    output logic       ORS,
    output logic       SRS,
    output logic       SUMS,
    output logic       n_ACIN,
    output logic       n_DAA,
    output logic       n_DSA,
    output logic       AC_SB,
    output logic       AC_DB,
    output logic       SB_AC,
    output logic       ADD_SB06,
    output logic       ADD_SB7,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       C_OUT,
    output logic       V_OUT
);

    seq_state_e state_q, state_d;
    logic [3:0] op_q;
    logic       d_q, c_q;
    logic       err_q, c_out_q, v_out_q;
    alu_ctrl_t  ctrl;

    logic accept, reject;
    assign accept = (state_q == ST_IDLE) && START &&  op_legal(OP);
    assign reject = (state_q == ST_IDLE) && START && !op_legal(OP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_OPER;
            ST_OPER:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PHI2 or posedge RES) begin
        if (RES) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADC;
            d_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            c_out_q <= 1'b0;
            v_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= reject;
            if (accept) begin
                op_q <= OP;
                d_q  <= D_FLAG;
                c_q  <= C_IN;
            end
            if (state_q == ST_OPER) begin
                if (op_sets_c(op_q)) c_out_q <= ACR;
                if (op_sets_v(op_q)) v_out_q <= AVR;
            end
        end
    end

    alu_op_decode u_decode (
        .state (state_q),
        .op    (op_q),
        .d_lat (d_q),
        .c_lat (c_q),
        .ctrl  (ctrl)
    );

    assign SB_ADD   = ctrl.sb_add;
    assign DB_ADD   = ctrl.db_add;
    assign NDB_ADD  = ctrl.ndb_add;
    assign Z_ADD    = ctrl.z_add;
    assign ADL_ADD  = ctrl.adl_add;
    assign ANDS     = ctrl.ands;
    assign EORS     = ctrl.eors;
    assign ORS      = ctrl.ors;
    assign SRS      = ctrl.srs;
    assign SUMS     = ctrl.sums;
    assign n_ACIN   = ctrl.n_acin;
    assign n_DAA    = ctrl.n_daa;
    assign n_DSA    = ctrl.n_dsa;
    assign AC_SB    = ctrl.ac_sb;
    assign AC_DB    = ctrl.ac_db;
    assign SB_AC    = ctrl.sb_ac;
    assign ADD_SB06 = ctrl.add_sb06;
    assign ADD_SB7  = ctrl.add_sb7;
    assign BUSY     = ctrl.busy;
    assign DONE     = ctrl.done;
    assign ERR      = err_q;
    assign C_OUT    = c_out_q;
    assign V_OUT    = v_out_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Directed-vector bench: all outputs are packed into one word and compared
//   against hand-built expected words assembled from per-signal bit masks.
module tb_alu_sequencer;

    logic       PHI2 = 1'b0;
    logic       RES = 1'b1;
    logic       START = 1'b0;
    logic [3:0] OP = 4'd0;
    logic       D_FLAG = 1'b0;
    logic       C_IN = 1'b0;
    logic       ACR = 1'b0;
    logic       AVR = 1'b0;
    logic SB_ADD, DB_ADD, NDB_ADD, Z_ADD, ADL_ADD, ANDS, EORS, ORS, SRS, SUMS;
    logic n_ACIN, n_DAA, n_DSA, AC_SB, AC_DB, SB_AC, ADD_SB06, ADD_SB7;
    logic BUSY, DONE, ERR, C_OUT, V_OUT;

    int n_chk = 0;
    int n_fail = 0;

    alu_sequencer dut (
        .PHI2(PHI2), .RES(RES), .START(START), .OP(OP), .D_FLAG(D_FLAG),
        .C_IN(C_IN), .ACR(ACR), .AVR(AVR),
        .SB_ADD(SB_ADD), .DB_ADD(DB_ADD), .NDB_ADD(NDB_ADD), .Z_ADD(Z_ADD),
        .ADL_ADD(ADL_ADD), .ANDS(ANDS), .EORS(EORS), .ORS(ORS), .SRS(SRS),
        .SUMS(SUMS), .n_ACIN(n_ACIN), .n_DAA(n_DAA), .n_DSA(n_DSA),
        .AC_SB(AC_SB), .AC_DB(AC_DB), .SB_AC(SB_AC), .ADD_SB06(ADD_SB06),
        .ADD_SB7(ADD_SB7), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .C_OUT(C_OUT), .V_OUT(V_OUT)
    );

    always #5 PHI2 = ~PHI2;

    logic [22:0] outs;
    assign outs = {SB_ADD, DB_ADD, NDB_ADD, Z_ADD, ADL_ADD, ANDS, EORS, ORS,
                   SRS, SUMS, n_ACIN, n_DAA, n_DSA, AC_SB, AC_DB, SB_AC,
                   ADD_SB06, ADD_SB7, BUSY, DONE, ERR, C_OUT, V_OUT};

    localparam logic [22:0] B_SB_ADD = 23'd1 << 22, B_DB_ADD = 23'd1 << 21,
        B_NDB_ADD = 23'd1 << 20, B_Z_ADD = 23'd1 << 19, B_ANDS = 23'd1 << 17,
        B_ORS = 23'd1 << 15, B_SUMS = 23'd1 << 13, B_NACIN = 23'd1 << 12,
        B_NDAA = 23'd1 << 11, B_NDSA = 23'd1 << 10, B_AC_SB = 23'd1 << 9,
        B_AC_DB = 23'd1 << 8, B_SB_AC = 23'd1 << 7, B_SB06 = 23'd1 << 6,
        B_SB7 = 23'd1 << 5, B_BUSY = 23'd1 << 4, B_DONE = 23'd1 << 3,
        B_ERR = 23'd1 << 2, B_C = 23'd1 << 1, B_V = 23'd1;
    // Idle word: only the active-low lines high.
    localparam logic [22:0] NI = B_NACIN | B_NDAA | B_NDSA;
    localparam logic [22:0] LD = NI | B_BUSY | B_AC_SB | B_SB_ADD;
    localparam logic [22:0] WR = NI | B_BUSY | B_SB06 | B_SB7 | B_DONE;

    task automatic tick();
        @(posedge PHI2);
        #1;
    endtask

    task automatic test_reset();
        RES = 1'b1;
        tick(); tick();
        n_chk++; if (outs !== NI) begin n_fail++; $display("FAIL reset: got %h want %h", outs, NI); end
        RES = 1'b0;
        tick();
        n_chk++; if (outs !== NI) begin n_fail++; $display("FAIL reset_idle: got %h want %h", outs, NI); end
    endtask

    task automatic test_adc();
        OP = 4'd0; D_FLAG = 1'b0; C_IN = 1'b1; ACR = 1'b1; AVR = 1'b0; START = 1'b1;
        tick(); START = 1'b0;
        n_chk++; if (outs !== (LD | B_DB_ADD)) begin n_fail++; $display("FAIL adc_load: got %h want %h", outs, LD | B_DB_ADD); end
        tick();
        n_chk++; if (outs !== (B_BUSY | B_SUMS | B_NDAA | B_NDSA)) begin n_fail++; $display("FAIL adc_oper: got %h want %h", outs, B_BUSY | B_SUMS | B_NDAA | B_NDSA); end
        tick();
        n_chk++; if (outs !== (WR | B_SB_AC | B_C)) begin n_fail++; $display("FAIL adc_write: got %h want %h", outs, WR | B_SB_AC | B_C); end
        tick();
        n_chk++; if (outs !== (NI | B_C)) begin n_fail++; $display("FAIL adc_idle: got %h want %h", outs, NI | B_C); end
    endtask

    task automatic test_sbc();
        OP = 4'd1; D_FLAG = 1'b1; C_IN = 1'b0; ACR = 1'b0; AVR = 1'b1; START = 1'b1;
        tick(); START = 1'b0;
        n_chk++; if (outs !== (LD | B_NDB_ADD | B_C)) begin n_fail++; $display("FAIL sbc_load: got %h want %h", outs, LD | B_NDB_ADD | B_C); end
        tick();
        n_chk++; if (outs !== (B_BUSY | B_SUMS | B_NACIN | B_NDAA | B_C)) begin n_fail++; $display("FAIL sbc_oper: got %h want %h", outs, B_BUSY | B_SUMS | B_NACIN | B_NDAA | B_C); end
        tick();
        n_chk++; if (outs !== (WR | B_SB_AC | B_V)) begin n_fail++; $display("FAIL sbc_write: got %h want %h", outs, WR | B_SB_AC | B_V); end
        tick();
    endtask

    task automatic test_cmp();
        OP = 4'd5; D_FLAG = 1'b1; C_IN = 1'b0; ACR = 1'b1; AVR = 1'b0; START = 1'b1;
        tick(); START = 1'b0;
        n_chk++; if (outs !== (LD | B_NDB_ADD | B_V)) begin n_fail++; $display("FAIL cmp_load: got %h want %h", outs, LD | B_NDB_ADD | B_V); end
        tick();
        n_chk++; if (outs !== (B_BUSY | B_SUMS | B_NDAA | B_NDSA | B_V)) begin n_fail++; $display("FAIL cmp_oper: got %h want %h", outs, B_BUSY | B_SUMS | B_NDAA | B_NDSA | B_V); end
        tick();
        n_chk++; if (outs !== (WR | B_C | B_V)) begin n_fail++; $display("FAIL cmp_write: got %h want %h", outs, WR | B_C | B_V); end
        tick();
    endtask

    task automatic test_illegal_then_and();
        OP = 4'd12; D_FLAG = 1'b0; C_IN = 1'b0; ACR = 1'b0; AVR = 1'b0; START = 1'b1;
        tick(); START = 1'b0;
        n_chk++; if (outs !== (NI | B_ERR | B_C | B_V)) begin n_fail++; $display("FAIL illegal_err: got %h want %h", outs, NI | B_ERR | B_C | B_V); end
        tick();
        n_chk++; if (outs !== (NI | B_C | B_V)) begin n_fail++; $display("FAIL illegal_after: got %h want %h", outs, NI | B_C | B_V); end
        OP = 4'd2; START = 1'b1;
        tick(); START = 1'b0;
        n_chk++; if (outs !== (LD | B_DB_ADD | B_C | B_V)) begin n_fail++; $display("FAIL and_load: got %h want %h", outs, LD | B_DB_ADD | B_C | B_V); end
        tick();
        n_chk++; if (outs !== (B_BUSY | B_ANDS | NI | B_C | B_V)) begin n_fail++; $display("FAIL and_oper: got %h want %h", outs, B_BUSY | B_ANDS | NI | B_C | B_V); end
        tick();
        n_chk++; if (outs !== (WR | B_SB_AC | B_C | B_V)) begin n_fail++; $display("FAIL and_write: got %h want %h", outs, WR | B_SB_AC | B_C | B_V); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        OP = 4'd3; ACR = 1'b0; AVR = 1'b0; START = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_done = ((i % 4) == 3);
            n_chk++; if (DONE !== exp_done) begin n_fail++; $display("FAIL b2b_done cycle %0d: got %b want %b", i, DONE, exp_done); end
        end
        START = 1'b0;
        tick();
        n_chk++; if (outs !== (NI | B_C | B_V)) begin n_fail++; $display("FAIL b2b_idle: got %h want %h", outs, NI | B_C | B_V); end
    endtask

    task automatic test_reset_mid();
        OP = 4'd7; C_IN = 1'b1; D_FLAG = 1'b0; ACR = 1'b0; AVR = 1'b0; START = 1'b1;
        tick(); START = 1'b0;
        n_chk++; if (outs !== (LD | B_AC_DB | B_DB_ADD | B_C | B_V)) begin n_fail++; $display("FAIL rol_load: got %h want %h", outs, LD | B_AC_DB | B_DB_ADD | B_C | B_V); end
        tick();
        n_chk++; if (outs !== (B_BUSY | B_SUMS | B_NDAA | B_NDSA | B_C | B_V)) begin n_fail++; $display("FAIL rol_oper: got %h want %h", outs, B_BUSY | B_SUMS | B_NDAA | B_NDSA | B_C | B_V); end
        #2 RES = 1'b1;
        #1;
        n_chk++; if (outs !== NI) begin n_fail++; $display("FAIL mid_reset: got %h want %h", outs, NI); end
        #1 RES = 1'b0;
        OP = 4'd9; C_IN = 1'b0; ACR = 1'b1; AVR = 1'b1; START = 1'b1;
        tick(); START = 1'b0;
        n_chk++; if (outs !== (LD | B_Z_ADD)) begin n_fail++; $display("FAIL inc_load: got %h want %h", outs, LD | B_Z_ADD); end
        tick();
        n_chk++; if (outs !== (B_BUSY | B_SUMS | B_NDAA | B_NDSA)) begin n_fail++; $display("FAIL inc_oper: got %h want %h", outs, B_BUSY | B_SUMS | B_NDAA | B_NDSA); end
        tick();
        n_chk++; if (outs !== (WR | B_SB_AC)) begin n_fail++; $display("FAIL inc_write: got %h want %h", outs, WR | B_SB_AC); end
        tick();
        n_chk++; if (outs !== NI) begin n_fail++; $display("FAIL inc_idle: got %h want %h", outs, NI); end
    endtask

    initial begin
        test_reset();
        test_adc();
        test_sbc();
        test_cmp();
        test_illegal_then_and();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequences the 6502-style ALU datapath for one accumulator operation per request. It drives the ALU input-select, operation-select, carry and decimal-control lines, and the accumulator/bus transfer lines over a fixed three-cycle LOAD/OPER/WRITE pattern. It captures the ALU's ACR/AVR outputs into carry/overflow flags. It sits between the instruction decode logic (requester) and the ALU/accumulator/bus fabric.

## Interface
Parameters:
- none (opcode encoding fixed in package)

Ports:
- PHI2  in  1  clock; all state changes on rising edge
- RES  in  1  reset, asynchronous, active-high
- START  in  1  request; sampled only in IDLE
- OP  in  4  operation: 0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 ASL, 7 ROL, 8 LSR, 9 INC; 10–15 illegal
- D_FLAG  in  1  decimal mode
- C_IN  in  1  current carry flag
- ACR, AVR  in  1 each  ALU carry / overflow results
- SB_ADD, DB_ADD, NDB_ADD, Z_ADD, ADL_ADD  out  1 each  ALU input selects
- ANDS, EORS, ORS, SRS, SUMS  out  1 each  ALU operation selects
- n_ACIN, n_DAA, n_DSA  out  1 each  active-low carry-in, decimal add, decimal subtract
- AC_SB, AC_DB, SB_AC, ADD_SB06, ADD_SB7  out  1 each  transfer controls
- BUSY  out  1  high in LOAD/OPER/WRITE
- DONE  out  1  one-cycle pulse in WRITE
- ERR  out  1  one-cycle pulse on illegal OP
- C_OUT, V_OUT  out  1 each  registered carry / overflow flags

## Operation
- States: IDLE, LOAD, OPER, WRITE.
- IDLE:
  - START=1 and legal OP → LOAD; latch OP, D_FLAG, C_IN.
  - START=1 and illegal OP → ERR=1 for the next cycle; stay in IDLE.
- LOAD:
  - Always AC_SB=1 and SB_ADD=1.
  - B input:
    - ADC/AND/ORA/EOR → DB_ADD.
    - SBC/CMP → NDB_ADD.
    - ASL/ROL → AC_DB=1 and DB_ADD (A+A).
    - LSR/INC → Z_ADD.
- OPER: exactly one op select.
  - SUMS for ADC/SBC/CMP/ASL/ROL/INC.
  - ANDS, ORS, EORS for AND, ORA, EOR respectively.
  - SRS for LSR.
- n_ACIN in OPER is the complement of the carry-in:
  - carry-in = latched C for ADC/SBC/ROL;
  - carry-in = 1 for CMP/INC;
  - carry-in = 0 for ASL/LSR/logic ops.
- Decimal controls in OPER:
  - n_DAA=0 only for ADC with latched D=1.
  - n_DSA=0 only for SBC with latched D=1.
- Flag capture at the end of OPER:
  - C_OUT←ACR for ADC/SBC/CMP/ASL/ROL/LSR; unchanged otherwise.
  - V_OUT←AVR for ADC/SBC only; unchanged otherwise.
- WRITE: ADD_SB06=ADD_SB7=1, DONE=1.
  - SB_AC=1 for every op except CMP.
  - WRITE → IDLE.
- Every control output not listed for a state is inactive. Inactive means 0, except n_* lines, which are inactive at 1.
- ADL_ADD is never asserted by this block; it is tied inactive.

## Timing
- START sampled at edge N → LOAD in cycle N+1, OPER in N+2, WRITE/DONE in N+3, IDLE in N+4.
- Back-to-back requests: START may be asserted in the WRITE cycle but is ignored. The earliest accepted START is the first IDLE cycle, giving a 4-cycle throughput.
- START while BUSY is ignored; it is not queued.
- ERR asserts in cycle N+1 after an illegal request; BUSY stays 0.
- Flags are visible from cycle N+3 (registered at the OPER→WRITE edge).
- Reset value of every output:
  - all active-high outputs 0;
  - n_ACIN, n_DAA, n_DSA = 1;
  - C_OUT = V_OUT = 0.
- Reset mid-operation: state returns immediately to IDLE and all outputs take their reset values asynchronously. No DONE is issued for the aborted op. The first START after RES deasserts is accepted normally.
- All outputs are registered or decoded from state plus latched OP only, so there is no combinational path from START to the ALU controls.

## Structure
- Package alu_seq_pkg holds:
  - the OP encoding constants (ADC…INC, illegal range ≥10);
  - the state enumeration;
  - a control-vector bundle type.
- Sub-module alu_op_decode: combinational; inputs are state, latched OP and latched D/C; output is the full control vector. The sequencer holds the FSM, the latches and the flag registers.

## Test plan
- ADC, D=0, C_IN=1, ACR model=1, AVR=0:
  - cycle1: AC_SB, SB_ADD, DB_ADD.
  - cycle2: SUMS, n_ACIN=0, n_DAA=1.
  - cycle3: SB_AC, DONE.
  - result: C_OUT=1, V_OUT=0.
- SBC, D=1, C_IN=0, AVR=1 → NDB_ADD in LOAD; n_DSA=0 and n_ACIN=1 in OPER; V_OUT=1.
- CMP → NDB_ADD, n_ACIN=0; SB_AC stays 0 in WRITE; DONE=1; C_OUT follows ACR.
- OP=12 → ERR pulse in the next cycle; BUSY=0; no control asserted. Then an AND request completes normally with ANDS in OPER and C_OUT unchanged.
- START held high continuously with ORA → DONE pulses every 4 cycles; a START presented in WRITE does not shorten the spacing.
- RES asserted during OPER of ROL → outputs at reset values in the same cycle and state IDLE; after release, an INC request gives Z_ADD then SUMS with n_ACIN=0, DONE at cycle 3.
